// File: rtl/cond_flag_pkg.sv
// Shared definitions for the status-flag path: ARM condition codes and the
// bit positions of {z,c,n,v} inside the status register.
package cond_flag_pkg;

    localparam int SR_W = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Purely combinational ARM condition evaluator; shared with the branch unit,
// so it carries no state and no knowledge of the pipeline.
module cond_check
    import cond_flag_pkg::*;
(
    input  logic [3:0]      cond,
    input  logic [SR_W-1:0] flags,
    output logic            pass
);

    logic z, c, n, v;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural status register plus the ID-stage condition verdict that is
// registered into the ID/EXE boundary, with stall/flush/flag-hazard handling.
module cond_flag_unit
    import cond_flag_pkg::*;
#(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sr_we,
    input  logic [SR_W-1:0]  alu_sr,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             stall,
    input  logic             flush,
    output logic [SR_W-1:0]  sr,
    output logic             exe_valid,
    output logic             cond_pass,
    output logic             flag_hazard,
    output logic [CNT_W-1:0] flag_wr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [SR_W-1:0] ef;
    logic            id_pass;

    // With bypass the verdict sees the flags being written this very edge;
    // without it ID must wait one cycle for sr to settle.
    always_comb begin
        ef          = sr;
        flag_hazard = 1'b0;
        if (BYPASS != 0) begin
            if (sr_we) ef = alu_sr;
        end else begin
            flag_hazard = id_valid && sr_we && (id_cond != COND_AL);
        end
    end

    cond_check u_cond_check (
        .cond  (id_cond),
        .flags (ef),
        .pass  (id_pass)
    );

    // Status register and write counter ignore stall/flush entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr          <= '0;
            flag_wr_cnt <= '0;
        end else if (sr_we) begin
            sr          <= alu_sr;
            flag_wr_cnt <= flag_wr_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_valid <= 1'b0;
            cond_pass <= 1'b0;
        end else if (flush) begin
            exe_valid <= 1'b0;
            cond_pass <= 1'b0;
        end else if (stall) begin
            exe_valid <= exe_valid;
            cond_pass <= cond_pass;
        end else if (flag_hazard) begin
            exe_valid <= 1'b0;
            cond_pass <= 1'b0;
        end else begin
            exe_valid <= id_valid;
            cond_pass <= id_valid && id_pass;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed plus random stimulus against both BYPASS variants, with a
// reference model feeding an expected-result queue checked after each edge.
module tb_cond_flag_unit;

    logic       clk;
    logic       rst;
    logic       sr_we;
    logic [3:0] alu_sr;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       stall;
    logic       flush;

    logic [3:0] sr1, sr0;
    logic       ev1, ev0, cp1, cp0, fh1, fh0;
    logic [3:0] cnt1, cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    // {sr, cnt, ev1, cp1, ev0, cp0}
    logic [11:0] exp_q[$];

    logic [3:0] m_sr, m_cnt;
    logic       m_ev1, m_cp1, m_ev0, m_cp0;

    cond_flag_unit #(.BYPASS(1), .CNT_W(4)) dut_b1 (
        .clk(clk), .rst(rst), .sr_we(sr_we), .alu_sr(alu_sr),
        .id_valid(id_valid), .id_cond(id_cond), .stall(stall), .flush(flush),
        .sr(sr1), .exe_valid(ev1), .cond_pass(cp1), .flag_hazard(fh1),
        .flag_wr_cnt(cnt1)
    );

    cond_flag_unit #(.BYPASS(0), .CNT_W(4)) dut_b0 (
        .clk(clk), .rst(rst), .sr_we(sr_we), .alu_sr(alu_sr),
        .id_valid(id_valid), .id_cond(id_cond), .stall(stall), .flush(flush),
        .sr(sr0), .exe_valid(ev0), .cond_pass(cp0), .flag_hazard(fh0),
        .flag_wr_cnt(cnt0)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1; sr_we = 1'b0; alu_sr = '0; id_valid = 1'b0;
        id_cond = '0; stall = 1'b0; flush = 1'b0;
    end

    // ARM conditions come in complementary pairs: evaluate the even member
    // and invert for odd codes (AL/NV fall out as 1 / 0).
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic z, cf, n, v, base;
        {z, cf, n, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: one clock of stimulus, model update, and scoreboard pop
    task automatic step(input logic r, input logic we, input logic [3:0] asr,
                        input logic iv, input logic [3:0] ic,
                        input logic st, input logic fl);
        logic       haz0;
        logic [3:0] ef1;
        logic [11:0] got, exp;
        @(negedge clk);
        rst = r; sr_we = we; alu_sr = asr; id_valid = iv; id_cond = ic;
        stall = st; flush = fl;
        #1;
        haz0 = iv & we & (ic != 4'b1110);
        check("hazard_b0", {3'b0, fh0}, {3'b0, haz0});
        check("hazard_b1", {3'b0, fh1}, 4'h0);

        ef1 = we ? asr : m_sr;
        if (r) begin
            m_ev1 = 0; m_cp1 = 0;
        end else if (fl) begin
            m_ev1 = 0; m_cp1 = 0;
        end else if (!st) begin
            m_ev1 = iv; m_cp1 = iv & ref_cond(ic, ef1);
        end
        if (r) begin
            m_ev0 = 0; m_cp0 = 0;
        end else if (fl) begin
            m_ev0 = 0; m_cp0 = 0;
        end else if (!st) begin
            if (haz0) begin
                m_ev0 = 0; m_cp0 = 0;
            end else begin
                m_ev0 = iv; m_cp0 = iv & ref_cond(ic, m_sr);
            end
        end
        if (r) begin
            m_sr = 0; m_cnt = 0;
        end else if (we) begin
            m_sr = asr; m_cnt = m_cnt + 4'd1;
        end
        exp_q.push_back({m_sr, m_cnt, m_ev1, m_cp1, m_ev0, m_cp0});

        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got = {sr1, cnt1, ev1, cp1, ev0, cp0};
        check("sr_b1",  sr1,  exp[11:8]);
        check("sr_b0",  sr0,  exp[11:8]);
        check("cnt_b1", cnt1, exp[7:4]);
        check("cnt_b0", cnt0, exp[7:4]);
        check("ev_b1", {3'b0, got[3]}, {3'b0, exp[3]});
        check("cp_b1", {3'b0, got[2]}, {3'b0, exp[2]});
        check("ev_b0", {3'b0, got[1]}, {3'b0, exp[1]});
        check("cp_b0", {3'b0, got[0]}, {3'b0, exp[0]});
    endtask

    initial begin
        m_sr = 0; m_cnt = 0; m_ev1 = 0; m_cp1 = 0; m_ev0 = 0; m_cp0 = 0;

        // reset, idle
        step(1, 0, 4'h0, 0, 4'h0, 0, 0);
        step(1, 0, 4'h0, 0, 4'h0, 0, 0);
        step(0, 0, 4'h0, 0, 4'h0, 0, 0);
        check("tp_reset_sr", sr1, 4'h0);
        check("tp_reset_cnt", cnt1, 4'h0);

        // EQ with z=0
        step(0, 0, 4'h0, 1, 4'b0000, 0, 0);
        check("tp_eq_valid", {3'b0, ev1}, 4'h1);
        check("tp_eq_fail", {3'b0, cp1}, 4'h0);

        // write z, then EQ passes and NE fails
        step(0, 1, 4'b1000, 0, 4'h0, 0, 0);
        step(0, 0, 4'h0, 1, 4'b0000, 0, 0);
        check("tp_eq_pass", {3'b0, cp1}, 4'h1);
        step(0, 0, 4'h0, 1, 4'b0001, 0, 0);
        check("tp_ne_fail", {3'b0, cp1}, 4'h0);
        check("tp_sr_held", sr1, 4'b1000);

        // same-cycle write with GE: bypass sees n!=v, no-bypass bubbles
        step(0, 1, 4'b0101, 1, 4'b1010, 0, 0);
        check("tp_byp_ge", {3'b0, cp1}, 4'h0);
        check("tp_nobyp_bubble", {3'b0, ev0}, 4'h0);
        step(0, 0, 4'h0, 1, 4'b1010, 0, 0);
        check("tp_nobyp_retry_v", {3'b0, ev0}, 4'h1);
        check("tp_nobyp_retry_p", {3'b0, cp0}, 4'h0);

        // bypass-sensitive: clear z while ID evaluates NE
        step(0, 1, 4'b1000, 0, 4'h0, 0, 0);
        step(0, 1, 4'b0000, 1, 4'b0001, 0, 0);
        check("tp_byp_new_flags", {3'b0, cp1}, 4'h1);
        step(0, 0, 4'h0, 1, 4'b0001, 0, 0);

        // AL never hazards
        step(0, 1, 4'b1000, 1, 4'b1110, 0, 0);
        check("tp_al_no_hazard", {3'b0, cp0}, 4'h1);

        // stall holds a passing verdict, flush during stall kills it
        step(0, 0, 4'h0, 1, 4'b1110, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 1, 4'b1111, 1, 0);
        check("tp_stall_hold", {3'b0, cp1}, 4'h1);
        step(0, 0, 4'h0, 1, 4'b1110, 1, 1);
        check("tp_flush_stall", {3'b0, ev1}, 4'h0);

        // counter wrap over 17 writes
        step(1, 0, 4'h0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 17; i++)
            step(0, 1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 0, 0);
        check("tp_cnt_wrap", cnt1, 4'd1);

        // reset mid-stall and mid-hazard
        step(0, 1, 4'b1000, 1, 4'b1110, 0, 0);
        step(1, 1, 4'b0110, 1, 4'b0000, 1, 0);
        check("tp_rst_sr", sr0, 4'h0);
        check("tp_rst_ev", {3'b0, ev0}, 4'h0);
        step(0, 0, 4'h0, 0, 4'h0, 0, 0);

        // random mix
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
